ntt_coef_loader: RTL and testbench

Upstream stage of the Kyber NTT/INTT wrapper.
- Accepts a 32-bit valid/ready stream of packed coefficient pairs from the HPS bridge.
- Range-checks each coefficient against Q, then drives the wrapper's load port (start, we, address_ina/address_inb, data_ina/data_inb) to fill all 256 entries.
- Releases start, then waits for the wrapper's done, so software sees one transaction per polynomial.

---
 rtl/ntt_pkg.sv | 25 ++
 rtl/coef_reduce.sv | 36 +++
 rtl/ntt_coef_loader.sv | 205 ++++++++++++++++++++
 tb/tb_ntt_coef_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntt_pkg
// Description : Shared constants, state encoding and data types for the
//               Kyber NTT coefficient loader.
// Revision    : 1.0 - initial release
// ============================================================================
package ntt_pkg;

  localparam int unsigned Q           = 3329;
  localparam int unsigned N_PAIRS     = 128;
  localparam int unsigned TIMEOUT_CYC = 4096;

  typedef logic [7:0]  addr_t;
  typedef logic [15:0] coef_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    KICK = 2'd2,
    WAIT = 2'd3
  } state_t;

endpackage : ntt_pkg
`default_nettype wire

// File: rtl/coef_reduce.sv
`default_nettype none
// ============================================================================
// Module      : coef_reduce
// Description : Combinational range check and single-step reduction of one
//               16-bit coefficient against the modulus.
// Revision    : 1.0 - initial release
// ============================================================================
module coef_reduce
  import ntt_pkg::*;
#(
  parameter int unsigned QMOD = ntt_pkg::Q
) (
  input  coef_t c_i,
  output coef_t r_o,
  output logic  bad_o
);

  localparam coef_t C_Q  = coef_t'(QMOD);
  localparam coef_t C_Q2 = coef_t'(2 * QMOD);

  // Values below Q pass, one modulus is removed below 2Q, anything larger is forced to 0
  always_comb begin
    r_o   = '0;
    bad_o = 1'b0;
    if (c_i < C_Q) begin
      r_o = c_i;
    end else if (c_i < C_Q2) begin
      r_o   = c_i - C_Q;
      bad_o = 1'b1;
    end else begin
      bad_o = 1'b1;
    end
  end

endmodule : coef_reduce
`default_nettype wire

// File: rtl/ntt_coef_loader.sv
`default_nettype none
// ============================================================================
// Module      : ntt_coef_loader
// Description : Streams 128 packed coefficient pairs into the NTT wrapper
//               load port, kicks the transform and waits for its done.
// Revision    : 1.0 - initial release
// ============================================================================
module ntt_coef_loader
  import ntt_pkg::*;
#(
  parameter int unsigned Q           = ntt_pkg::Q,
  parameter int unsigned N_PAIRS     = ntt_pkg::N_PAIRS,
  parameter int unsigned TIMEOUT_CYC = ntt_pkg::TIMEOUT_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        mode_in,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        core_start,
  output logic        core_mode,
  output logic        core_we,
  output logic [7:0]  core_addr_a,
  output logic [7:0]  core_addr_b,
  output logic [15:0] core_data_a,
  output logic [15:0] core_data_b,
  input  logic        core_done,
  output logic        busy,
  output logic        load_done,
  output logic        range_err,
  output logic        frame_err,
  output logic        timeout,
  output logic [7:0]  err_cnt
);

  localparam int unsigned KW = $clog2(N_PAIRS);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_PAIRS - 1);
  localparam logic [CW-1:0] T_LIM  = CW'(TIMEOUT_CYC);

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            mode_q, mode_d;
  logic            we_q, we_d;
  logic            start_q, start_d;
  addr_t           addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  coef_t           data_a_q, data_a_d, data_b_q, data_b_d;
  logic            load_done_q, load_done_d;
  logic            range_err_q, range_err_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            done_prev_q;

  coef_t           red_a, red_b;
  logic            bad_a, bad_b;
  logic [8:0]      err_sum;
  logic            beat;

  // Lane A carries the even coefficient in the upper half-word
  coef_reduce #(.QMOD(Q)) u_red_a (
    .c_i   (s_data[31:16]),
    .r_o   (red_a),
    .bad_o (bad_a)
  );

  coef_reduce #(.QMOD(Q)) u_red_b (
    .c_i   (s_data[15:0]),
    .r_o   (red_b),
    .bad_o (bad_b)
  );

  assign beat    = (state_q == LOAD) && s_valid;
  assign err_sum = {1'b0, err_cnt_q} + 9'(bad_a) + 9'(bad_b);

  // Next-state and registered-output logic for the load/kick/wait sequence
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    wcnt_d      = wcnt_q;
    mode_d      = mode_q;
    we_d        = 1'b0;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    range_err_d = range_err_q;
    frame_err_d = frame_err_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d     = LOAD;
          mode_d      = mode_in;
          k_d         = '0;
          range_err_d = 1'b0;
          frame_err_d = 1'b0;
          timeout_d   = 1'b0;
          err_cnt_d   = '0;
        end
      end
      LOAD: begin
        if (beat) begin
          we_d        = 1'b1;
          addr_a_d    = addr_t'({k_q, 1'b0});
          addr_b_d    = addr_t'({k_q, 1'b1});
          data_a_d    = red_a;
          data_b_d    = red_b;
          range_err_d = range_err_q | bad_a | bad_b;
          err_cnt_d   = err_sum[8] ? 8'hFF : err_sum[7:0];
          k_d         = k_q + KW'(1);
          if (k_q == K_LAST) begin
            state_d = KICK;
            if (!s_last) frame_err_d = 1'b1;
          end else if (s_last) begin
            // Short frame: the beat is still written, but the transform is not started
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      KICK: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      WAIT: begin
        if (core_done && !done_prev_q) begin
          state_d = IDLE;
        end else if (wcnt_q == T_LIM) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Start stays high through the cycle that presents the last write
    start_d     = (state_d == LOAD) || (state_d == KICK) || we_d;
    load_done_d = (state_d == KICK);
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      wcnt_q      <= '0;
      mode_q      <= 1'b0;
      we_q        <= 1'b0;
      start_q     <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      load_done_q <= 1'b0;
      range_err_q <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      wcnt_q      <= wcnt_d;
      mode_q      <= mode_d;
      we_q        <= we_d;
      start_q     <= start_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      load_done_q <= load_done_d;
      range_err_q <= range_err_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      done_prev_q <= core_done;
    end
  end

  assign s_ready     = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign core_start  = start_q;
  assign core_mode   = mode_q;
  assign core_we     = we_q;
  assign core_addr_a = addr_a_q;
  assign core_addr_b = addr_b_q;
  assign core_data_a = data_a_q;
  assign core_data_b = data_b_q;
  assign load_done   = load_done_q;
  assign range_err   = range_err_q;
  assign frame_err   = frame_err_q;
  assign timeout     = timeout_q;
  assign err_cnt     = err_cnt_q;

endmodule : ntt_coef_loader
`default_nettype wire

// File: tb/tb_ntt_coef_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntt_coef_loader
// Description : Directed self-checking bench for the NTT coefficient loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntt_coef_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        mode_in = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        core_start, core_mode, core_we;
  logic [7:0]  core_addr_a, core_addr_b;
  logic [15:0] core_data_a, core_data_b;
  logic        core_done = 1'b0;
  logic        busy, load_done, range_err, frame_err, timeout;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int ld_cnt = 0;
  int we_no_start = 0;
  logic [15:0] got_addr [0:255];
  logic [31:0] got_data [0:255];

  ntt_coef_loader dut (
    .clk         (clk),
    .rst         (rst),
    .go          (go),
    .mode_in     (mode_in),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .core_start  (core_start),
    .core_mode   (core_mode),
    .core_we     (core_we),
    .core_addr_a (core_addr_a),
    .core_addr_b (core_addr_b),
    .core_data_a (core_data_a),
    .core_data_b (core_data_b),
    .core_done   (core_done),
    .busy        (busy),
    .load_done   (load_done),
    .range_err   (range_err),
    .frame_err   (frame_err),
    .timeout     (timeout),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Capture every write presented to the wrapper
  always @(negedge clk) begin
    if (rst && core_we) begin
      if (wr_cnt < 256) begin
        got_addr[wr_cnt] = {core_addr_a, core_addr_b};
        got_data[wr_cnt] = {core_data_a, core_data_b};
      end
      wr_cnt = wr_cnt + 1;
      if (!core_start) we_no_start = we_no_start + 1;
    end
    if (rst && load_done) ld_cnt = ld_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {s_ready, core_start, core_mode, core_we, busy, load_done,
                          range_err, frame_err, timeout, err_cnt, core_addr_a, core_addr_b}, 64'd0);
    check({tag, "_data"}, {core_data_a, core_data_b}, 64'd0);
  endtask

  function automatic logic [31:0] beat_data(input int i, input int pat);
    logic [31:0] d;
    d = {16'(2 * i), 16'(2 * i + 1)};
    if (pat == 1 && i == 5) d = {16'd3329, 16'd6700};
    if (pat == 1 && i == 9) d = {16'd3330, 16'd0};
    if (pat == 2)           d = {16'd7000, 16'd7000};
    return d;
  endfunction

  function automatic logic [31:0] exp_data(input int i, input int pat);
    logic [31:0] d;
    d = {16'(2 * i), 16'(2 * i + 1)};
    if (pat == 1 && i == 5) d = {16'd0, 16'd0};
    if (pat == 1 && i == 9) d = {16'd1, 16'd0};
    if (pat == 2)           d = 32'd0;
    return d;
  endfunction

  task automatic start_txn(input logic m);
    wr_cnt = 0;
    ld_cnt = 0;
    we_no_start = 0;
    @(posedge clk); #1;
    go = 1'b1;
    mode_in = m;
    @(posedge clk); #1;
    go = 1'b0;
    mode_in = 1'b0;
  endtask

  task automatic send(input int n, input int last_at, input int pat);
    for (int i = 0; i < n; i++) begin
      if (i % 17 == 3) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = beat_data(i, pat);
      s_last  = (i == last_at);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic verify(input string tag, input int n, input int pat);
    int bad_addr;
    int bad_data;
    bad_addr = 0;
    bad_data = 0;
    for (int i = 0; i < n; i++) begin
      if (got_addr[i] !== {8'(2 * i), 8'(2 * i + 1)}) bad_addr++;
      if (got_data[i] !== exp_data(i, pat)) bad_data++;
    end
    check({tag, "_wr_cnt"}, wr_cnt, n);
    check({tag, "_addr"}, bad_addr, 0);
    check({tag, "_data"}, bad_data, 0);
    check({tag, "_we_no_start"}, we_no_start, 0);
  endtask

  // Raise core_done cleanly from low and expect return to IDLE on that edge
  task automatic done_rise(input string tag);
    @(posedge clk); #1;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    @(negedge clk);
    check(tag, busy, 1'b0);
  endtask

  initial begin
    int n;
    int bad;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Full NTT load, clean data
    start_txn(1'b0);
    send(128, 127, 0);
    @(negedge clk);
    check("t1_kick", {load_done, core_start, core_we, busy}, 4'b1111);
    check("t1_kick_addr", {core_addr_a, core_addr_b}, 16'hFEFF);
    @(negedge clk);
    check("t1_wait", {load_done, core_start, core_we, busy}, 4'b0001);
    done_rise("t1_done");
    verify("t1", 128, 0);
    check("t1_ld_cnt", ld_cnt, 1);
    check("t1_flags", {core_mode, range_err, frame_err, timeout, err_cnt}, 12'd0);

    // INTT load with out-of-range beats and a stale done level
    core_done = 1'b1;
    start_txn(1'b1);
    send(128, 127, 1);
    @(negedge clk);
    check("t2_kick", load_done, 1'b1);
    repeat (20) @(negedge clk);
    check("t2_stale_done", busy, 1'b1);
    @(posedge clk); #1;
    go = 1'b1;
    mode_in = 1'b0;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    check("t2_go_ignored", {busy, core_mode, err_cnt}, {1'b1, 1'b1, 8'd3});
    @(posedge clk); #1;
    core_done = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    core_done = 1'b1;
    @(negedge clk);
    check("t2_pre_edge", busy, 1'b1);
    @(negedge clk);
    check("t2_done_rise", busy, 1'b0);
    core_done = 1'b0;
    verify("t2", 128, 1);
    check("t2_flags", {range_err, frame_err, timeout, err_cnt}, {1'b1, 1'b0, 1'b0, 8'd3});

    // Short frame: s_last on beat 63
    start_txn(1'b0);
    send(64, 63, 0);
    @(negedge clk);
    check("t3_final", {busy, core_we, core_start, load_done}, 4'b0110);
    @(negedge clk);
    check("t3_idle", {busy, core_we, core_start, load_done}, 4'b0000);
    verify("t3", 64, 0);
    check("t3_ld_cnt", ld_cnt, 0);
    check("t3_frame_err", frame_err, 1'b1);

    // Missing s_last on beat 127, then the wrapper never answers
    start_txn(1'b0);
    send(128, -1, 0);
    @(negedge clk);
    check("t4_kick", {load_done, frame_err}, 2'b11);
    n = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("t4_wait_cycles", n, 4097);
    check("t4_timeout", {timeout, busy}, 2'b10);

    // Next go clears flags; every coefficient >= 2Q saturates the counter
    start_txn(1'b0);
    @(negedge clk);
    check("t5_go_clear", {timeout, frame_err, range_err, err_cnt, s_ready}, 12'd1);
    @(posedge clk); #1;
    send(128, 127, 2);
    @(negedge clk);
    check("t5_kick", load_done, 1'b1);
    done_rise("t5_done");
    verify("t5", 128, 2);
    check("t5_err_sat", {range_err, err_cnt}, {1'b1, 8'hFF});

    // Asynchronous reset in the middle of a load at k=40
    start_txn(1'b1);
    send(40, -1, 0);
    s_valid = 1'b1;
    s_data  = 32'h0001_0002;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (s_ready || busy || core_we) bad++;
    end
    check("post_rst_idle", bad, 0);
    s_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ntt_coef_loader
`default_nettype wire
